// File: rtl/cook_sequencer.sv
// Microwave cook-cycle sequencer: keypad BCD entry, 1 Hz countdown,
// magnetron gating and end-of-cook alarm.
module cook_sequencer #(
    parameter int TICK_DIV   = 100,
    parameter int ALARM_SECS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic [9:0] keypad,
    output logic       mag_on,
    output logic       alarm,
    output logic [2:0] state,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_COOK  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int ALARM_CYC = ALARM_SECS * TICK_DIV;
    localparam int CNT_TOP   = (ALARM_CYC > TICK_DIV) ? ALARM_CYC : TICK_DIV;
    localparam int CW        = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_CYC - 1);

    logic [2:0]    r_state;
    logic [15:0]   r_time;
    logic [CW-1:0] r_cnt;
    logic          r_mag;
    logic          r_alarm;
    logic          r_start_p;
    logic          r_stop_p;
    logic          r_clear_p;
    logic [9:0]    r_kp_prev;

    logic          w_start_ev;
    logic          w_stop_ev;
    logic          w_clear_ev;
    logic          w_onehot;
    logic          w_key_ev;
    logic [3:0]    w_digit;
    logic          w_zero;
    logic          w_tick;
    logic [15:0]   w_dec;
    logic          w_dec_zero;

    // Button levels are stored as "pressed" so reset clears the detectors.
    assign w_start_ev = ~startn & ~r_start_p;
    assign w_stop_ev  = ~stopn  & ~r_stop_p;
    assign w_clear_ev = ~clearn & ~r_clear_p;

    assign w_onehot = (keypad != 10'd0)
                   && ((keypad & (keypad - 10'd1)) == 10'd0);
    assign w_key_ev = (r_kp_prev == 10'd0) && w_onehot;

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) w_digit = 4'(i);
        end
    end

    assign w_zero = (r_time == 16'h0000);
    assign w_tick = (r_cnt == TICK_LAST);

    // One-second BCD decrement with mm:ss borrow rules.
    always_comb begin
        w_dec = r_time;
        if (r_time[3:0] != 4'd0) begin
            w_dec[3:0] = r_time[3:0] - 4'd1;
        end else begin
            w_dec[3:0] = 4'd9;
            if (r_time[7:4] != 4'd0) begin
                w_dec[7:4] = r_time[7:4] - 4'd1;
            end else begin
                w_dec[7:4] = 4'd5;
                if (r_time[11:8] != 4'd0) begin
                    w_dec[11:8] = r_time[11:8] - 4'd1;
                end else begin
                    w_dec[11:8]  = 4'd9;
                    w_dec[15:12] = r_time[15:12] - 4'd1;
                end
            end
        end
    end

    assign w_dec_zero = (w_dec == 16'h0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_time    <= 16'h0000;
            r_cnt     <= '0;
            r_mag     <= 1'b0;
            r_alarm   <= 1'b0;
            r_start_p <= 1'b0;
            r_stop_p  <= 1'b0;
            r_clear_p <= 1'b0;
            r_kp_prev <= 10'd0;
        end else begin
            r_start_p <= ~startn;
            r_stop_p  <= ~stopn;
            r_clear_p <= ~clearn;
            r_kp_prev <= keypad;
            if (w_clear_ev) begin
                r_state <= S_IDLE;
                r_time  <= 16'h0000;
                r_cnt   <= '0;
                r_mag   <= 1'b0;
                r_alarm <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_key_ev) begin
                            r_time  <= {r_time[11:0], w_digit};
                            r_state <= S_ENTRY;
                        end
                    end
                    S_ENTRY, S_PAUSE: begin
                        if (w_stop_ev) begin
                            r_state <= S_IDLE;
                            r_time  <= 16'h0000;
                        end else if (w_start_ev && door_closed && !w_zero) begin
                            r_state <= S_COOK;
                            r_mag   <= 1'b1;
                            r_cnt   <= '0;
                        end else if (w_key_ev && r_state == S_ENTRY) begin
                            r_time <= {r_time[11:0], w_digit};
                        end
                    end
                    S_COOK: begin
                        if (!door_closed || w_stop_ev) begin
                            r_state <= S_PAUSE;
                            r_mag   <= 1'b0;
                            r_cnt   <= '0;
                        end else if (w_tick) begin
                            r_cnt <= '0;
                            if (w_zero || w_dec_zero) begin
                                r_state <= S_DONE;
                                r_time  <= 16'h0000;
                                r_mag   <= 1'b0;
                                r_alarm <= 1'b1;
                            end else begin
                                r_time <= w_dec;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_DONE: begin
                        if (w_start_ev || w_stop_ev || w_key_ev
                            || r_cnt == ALARM_LAST) begin
                            r_state <= S_IDLE;
                            r_alarm <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_time  <= 16'h0000;
                        r_cnt   <= '0;
                        r_mag   <= 1'b0;
                        r_alarm <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mag_on   = r_mag;
    assign alarm    = r_alarm;
    assign state    = r_state;
    assign min_tens = r_time[15:12];
    assign min_ones = r_time[11:8];
    assign sec_tens = r_time[7:4];
    assign sec_ones = r_time[3:0];

endmodule

// File: tb/tb_cook_sequencer.sv
// Scoreboard bench for cook_sequencer: stimulus queues cycle-stamped
// expectations, a negedge monitor checks them.
module tb_cook_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       clearn = 1'b1;
    logic       door_closed = 1'b1;
    logic [9:0] keypad = 10'd0;
    logic       mag_on;
    logic       alarm;
    logic [2:0] state;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;

    cook_sequencer #(.TICK_DIV(4), .ALARM_SECS(2)) dut (
        .clk(clk),
        .rst(rst),
        .startn(startn),
        .stopn(stopn),
        .clearn(clearn),
        .door_closed(door_closed),
        .keypad(keypad),
        .mag_on(mag_on),
        .alarm(alarm),
        .state(state),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] at;
        logic [95:0] nm;
        logic [2:0]  st;
        logic        mag;
        logic        alm;
        logic [15:0] t;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic expect_at(input int dly, input logic [95:0] nm,
                             input logic [2:0] st, input logic mag,
                             input logic alm, input logic [15:0] t);
        exp_t e;
        e.at  = 32'(cyc + dly);
        e.nm  = nm;
        e.st  = st;
        e.mag = mag;
        e.alm = alm;
        e.t   = t;
        q.push_back(e);
    endtask

    exp_t        m_e;
    logic [15:0] m_t;
    always @(negedge clk) begin
        m_t = {min_tens, min_ones, sec_tens, sec_ones};
        for (int i = q.size() - 1; i >= 0; i--) begin
            m_e = q[i];
            if (m_e.at == 32'(cyc)) begin
                total++;
                if (state !== m_e.st || mag_on !== m_e.mag
                    || alarm !== m_e.alm || m_t !== m_e.t) begin
                    bad++;
                    $display("FAIL %0s: got st=%0d mag=%0b alm=%0b t=%h want st=%0d mag=%0b alm=%0b t=%h",
                             m_e.nm, state, mag_on, alarm, m_t,
                             m_e.st, m_e.mag, m_e.alm, m_e.t);
                end
                q.delete(i);
            end else if (m_e.at < 32'(cyc)) begin
                total++;
                bad++;
                $display("FAIL %0s: check missed at cycle %0d (now %0d)",
                         m_e.nm, m_e.at, cyc);
                q.delete(i);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input int d);
        keypad = 10'b1 << d;
        step();
        keypad = 10'd0;
        step();
    endtask

    task automatic press_start();
        startn = 1'b0;
        step();
        startn = 1'b1;
        step();
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        step();
        stopn = 1'b1;
        step();
    endtask

    task automatic press_clear();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        step();
    endtask

    initial begin
        step(3);
        expect_at(0, "rst", 3'd0, 1'b0, 1'b0, 16'h0000);
        step();
        rst = 1'b0;
        step();

        // 01:30 full cook through alarm
        key(1); key(3); key(0);
        expect_at(0, "entry0130", 3'd1, 1'b0, 1'b0, 16'h0130);
        expect_at(1, "start", 3'd2, 1'b1, 1'b0, 16'h0130);
        expect_at(4, "pretick", 3'd2, 1'b1, 1'b0, 16'h0130);
        expect_at(5, "tick1", 3'd2, 1'b1, 1'b0, 16'h0129);
        expect_at(121, "t30", 3'd2, 1'b1, 1'b0, 16'h0100);
        expect_at(125, "t31", 3'd2, 1'b1, 1'b0, 16'h0059);
        expect_at(360, "last", 3'd2, 1'b1, 1'b0, 16'h0001);
        expect_at(361, "done", 3'd4, 1'b0, 1'b1, 16'h0000);
        expect_at(368, "alarmend", 3'd4, 1'b0, 1'b1, 16'h0000);
        expect_at(369, "idle", 3'd0, 1'b0, 1'b0, 16'h0000);
        press_start();
        step(370);

        // 01:00 -> 00:59, then 00:99 -> 00:98
        key(1); key(0); key(0);
        expect_at(1, "start100", 3'd2, 1'b1, 1'b0, 16'h0100);
        expect_at(5, "t059", 3'd2, 1'b1, 1'b0, 16'h0059);
        press_start();
        step(3);
        expect_at(1, "clr1", 3'd0, 1'b0, 1'b0, 16'h0000);
        press_clear();
        key(9); key(9);
        expect_at(0, "k99", 3'd1, 1'b0, 1'b0, 16'h0099);
        expect_at(5, "t098", 3'd2, 1'b1, 1'b0, 16'h0098);
        press_start();
        step(3);
        expect_at(1, "clr2", 3'd0, 1'b0, 1'b0, 16'h0000);
        press_clear();

        // door open pauses, close does not resume, start resumes
        key(4); key(5);
        startn = 1'b0;
        step();
        startn = 1'b1;
        door_closed = 1'b0;
        expect_at(0, "cook45", 3'd2, 1'b1, 1'b0, 16'h0045);
        expect_at(1, "dooropen", 3'd3, 1'b0, 1'b0, 16'h0045);
        step(20);
        expect_at(0, "frozen", 3'd3, 1'b0, 1'b0, 16'h0045);
        door_closed = 1'b1;
        step(3);
        expect_at(0, "closed", 3'd3, 1'b0, 1'b0, 16'h0045);
        expect_at(1, "resume", 3'd2, 1'b1, 1'b0, 16'h0045);
        expect_at(4, "pre44", 3'd2, 1'b1, 1'b0, 16'h0045);
        expect_at(5, "t044", 3'd2, 1'b1, 1'b0, 16'h0044);
        press_start();
        step(3);
        expect_at(1, "stopcook", 3'd3, 1'b0, 1'b0, 16'h0044);
        press_stop();
        expect_at(1, "stoppause", 3'd0, 1'b0, 1'b0, 16'h0000);
        press_stop();

        // start refused: door open, then time zero
        key(2);
        door_closed = 1'b0;
        expect_at(1, "startdoor", 3'd1, 1'b0, 1'b0, 16'h0002);
        press_start();
        door_closed = 1'b1;
        expect_at(1, "clr3", 3'd0, 1'b0, 1'b0, 16'h0000);
        press_clear();
        key(0);
        expect_at(0, "key0", 3'd1, 1'b0, 1'b0, 16'h0000);
        expect_at(1, "startzero", 3'd1, 1'b0, 1'b0, 16'h0000);
        press_start();
        expect_at(1, "clr4", 3'd0, 1'b0, 1'b0, 16'h0000);
        press_clear();

        // multi-key ignored, held key captured once
        keypad = 10'h028;
        step();
        keypad = 10'h008;
        step(2);
        keypad = 10'd0;
        step();
        expect_at(0, "multi", 3'd0, 1'b0, 1'b0, 16'h0000);
        keypad = 10'h080;
        step(10);
        keypad = 10'd0;
        step();
        expect_at(0, "held7", 3'd1, 1'b0, 1'b0, 16'h0007);

        // async reset during cook
        expect_at(1, "cook7", 3'd2, 1'b1, 1'b0, 16'h0007);
        press_start();
        step();
        rst = 1'b1;
        expect_at(0, "asyncrst", 3'd0, 1'b0, 1'b0, 16'h0000);
        step();
        rst = 1'b0;
        step();

        // clear wins over coincident tick and door open
        key(2); key(0);
        press_start();
        step(2);
        clearn = 1'b0;
        door_closed = 1'b0;
        expect_at(0, "pre20", 3'd2, 1'b1, 1'b0, 16'h0020);
        expect_at(1, "clrtick", 3'd0, 1'b0, 1'b0, 16'h0000);
        step();
        clearn = 1'b1;
        door_closed = 1'b1;
        step();

        // key during alarm exits early without capture
        key(1);
        expect_at(5, "done1", 3'd4, 1'b0, 1'b1, 16'h0000);
        press_start();
        step(4);
        keypad = 10'h020;
        expect_at(1, "doneexit", 3'd0, 1'b0, 1'b0, 16'h0000);
        step();
        keypad = 10'd0;
        expect_at(3, "idleafter", 3'd0, 1'b0, 1'b0, 16'h0000);
        step(4);

        for (int i = 0; i < 1000 && q.size() != 0; i++) step();
        if (q.size() != 0) begin
            $display("FAIL drain: %0d checks never reached", q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
